// File: rtl/booth_csa_mul32_if.sv
// Operand/result bundle between the MUL issue stage and booth_csa_mul32.
// The master presents operands; the slave (the multiplier) returns carry-save vectors.
interface booth_csa_mul32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_signed;
  logic        out_valid;
  logic [63:0] sum_vec;
  logic [63:0] carry_vec;

  modport master (
    output in_valid, op_a, op_b, is_signed,
    input  in_ready, out_valid, sum_vec, carry_vec
  );

  modport slave (
    input  in_valid, op_a, op_b, is_signed,
    output in_ready, out_valid, sum_vec, carry_vec
  );
endinterface

// File: rtl/booth_csa_mul32.sv
// Iterative radix-4 Booth 32x32 multiplier, one digit per cycle, accumulating in carry-save form.
// sum_vec + carry_vec equals the 64-bit product; final carry resolution happens downstream.
module booth_csa_mul32 (
  input  logic                 clk,
  input  logic                 reset,
  booth_csa_mul32_if.slave     bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [33:0] a_q, a_d;
  logic [34:0] b_q, b_d;
  logic [63:0] s_q, s_d, c_q, c_d;
  logic [63:0] sum_q, sum_d, carry_q, carry_d;

  logic        accept;
  logic [2:0]  digit;
  logic        neg, one, two;
  logic [63:0] a_sext, pp_mag, pp_shift, pp;

  assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum_vec   = sum_q;
  assign bus.carry_vec = carry_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // b_q carries the implicit zero below bit 0, so digit k sits at b_q[2k+2:2k]
  assign digit    = b_q[{cnt_q, 1'b0} +: 3];
  assign one      = (digit == 3'b001) || (digit == 3'b010) ||
                    (digit == 3'b101) || (digit == 3'b110);
  assign two      = (digit == 3'b011) || (digit == 3'b100);
  assign neg      = digit[2] && (digit != 3'b111);
  assign a_sext   = {{30{a_q[33]}}, a_q};
  assign pp_mag   = two ? (a_sext << 1) : (one ? a_sext : 64'd0);
  assign pp_shift = pp_mag << {cnt_q, 1'b0};
  assign pp       = neg ? ~pp_shift : pp_shift;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          cnt_d   = 5'd0;
          s_d     = 64'd0;
          c_d     = 64'd0;
          a_d     = bus.is_signed ? {{2{bus.op_a[31]}}, bus.op_a} : {2'b00, bus.op_a};
          b_d     = bus.is_signed ? {{2{bus.op_b[31]}}, bus.op_b, 1'b0}
                                  : {2'b00, bus.op_b, 1'b0};
        end
      end
      RUN: begin
        // The +1 completing the two's-complement negate rides in the free carry LSB
        s_d   = s_q ^ c_q ^ pp;
        c_d   = (((s_q & c_q) | (s_q & pp) | (c_q & pp)) << 1) | {63'd0, neg};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd16) begin
          state_d = DONE;
          sum_d   = s_d;
          carry_d = c_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 34'd0;
      b_q     <= 35'd0;
      s_q     <= 64'd0;
      c_q     <= 64'd0;
      sum_q   <= 64'd0;
      carry_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end
endmodule

// File: tb/tb_booth_csa_mul32.sv
// Directed bench for booth_csa_mul32: latency, boundary products, back-to-back issue and mid-run reset.
module tb_booth_csa_mul32;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  booth_csa_mul32_if bus ();

  booth_csa_mul32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h want 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one op from a negedge, wait for out_valid; returns product and cycles after accept.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [63:0] prod, output int lat);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.is_signed = sgn;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    prod = bus.sum_vec + bus.carry_vec;
  endtask

  task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp);
    logic [63:0] prod;
    int          lat;
    run_op(a, b, sgn, prod, lat);
    check({tag, "_lat"}, 64'(lat), 64'd17);
    check(tag, prod, exp);
  endtask

  initial begin
    logic [63:0] prod;
    int          lat;
    int          gap;
    int          pulses;

    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum",       bus.sum_vec,        64'd0);
    check("rst_carry",     bus.carry_vec,      64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, 1'b0, prod, lat);
    check("u3x5_lat", 64'(lat), 64'd17);
    check("u3x5", prod, 64'h0000_0000_0000_000F);
    check("u3x5_ready_done", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("u3x5_pulse_width", 64'(bus.out_valid), 64'd0);
    check("u3x5_hold", bus.sum_vec + bus.carry_vec, 64'h0000_0000_0000_000F);

    do_vec("u_ffff_sq",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    do_vec("s_m1_sq",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    do_vec("s_min_sq",    32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    do_vec("s_min_x1",    32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
    do_vec("u_min_sq",    32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
    do_vec("u_ff_x2",     32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE);
    do_vec("s_m1_x2",     32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    do_vec("s_7xm3",      32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    do_vec("u_10000_sq",  32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
    do_vec("u_min_xff",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h7FFF_FFFF_8000_0000);
    do_vec("s_min_xm1",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
    do_vec("s_max_sq",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001);

    // Mid-run reset: the aborted op must never produce out_valid
    @(negedge clk);
    bus.op_a      = 32'd100;
    bus.op_b      = 32'd200;
    bus.is_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_sum",       bus.sum_vec,        64'd0);
    check("arst_carry",     bus.carry_vec,      64'd0);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready",  64'(bus.in_ready),  64'd1);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    check("arst_no_pulse", 64'(pulses), 64'd0);
    do_vec("post_rst_2x3", 32'd2, 32'd3, 1'b0, 64'd6);

    // Back-to-back: in_valid held high, new operands in DONE, junk while RUN
    @(negedge clk);
    bus.op_a      = 32'd7;
    bus.op_b      = 32'd9;
    bus.is_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.op_a = 32'h0000_DEAD;
    bus.op_b = 32'h0000_BEEF;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_lat", 64'(lat), 64'd17);
    check("b2b_7x9", bus.sum_vec + bus.carry_vec, 64'h0000_0000_0000_003F);
    bus.op_a = 32'd0;
    bus.op_b = 32'h1234_5678;
    @(negedge clk);
    gap = 1;
    while (!bus.out_valid && gap < 40) begin
      bus.op_a     = 32'h0000_FFFF;
      bus.op_b     = 32'h0000_FFFF;
      bus.in_valid = gap[0];
      @(negedge clk);
      gap++;
    end
    bus.in_valid = 1'b0;
    check("b2b_gap", 64'(gap), 64'd18);
    check("b2b_0x", bus.sum_vec + bus.carry_vec, 64'd0);
    @(negedge clk);
    check("b2b_end_idle", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
